// File: rtl/stopwatch_pkg.sv
// Shared state encoding, key indices and state helpers for the stopwatch controller.
package stopwatch_pkg;

  // Bit 0 = running and bit 1 = counting down, so each press toggles exactly one bit.
  typedef enum logic [1:0] {
    PAUSED_UP   = 2'd0,
    RUN_UP      = 2'd1,
    PAUSED_DOWN = 2'd2,
    RUN_DOWN    = 2'd3
  } sw_state_e;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned KEY_RUN  = 0;
  localparam int unsigned KEY_DIR  = 1;
  localparam int unsigned KEY_LAP  = 2;
  localparam int unsigned KEY_CLR  = 3;

  function automatic logic is_running(input sw_state_e s);
    return (s == RUN_UP) || (s == RUN_DOWN);
  endfunction

  function automatic logic is_up(input sw_state_e s);
    return (s == PAUSED_UP) || (s == RUN_UP);
  endfunction

  // Run and dir presses are independent toggles, so both may apply in one cycle.
  function automatic sw_state_e toggle_state(input sw_state_e s,
                                             input logic      run_tgl,
                                             input logic      dir_tgl);
    logic      running;
    logic      down;
    logic      legal;
    sw_state_e nxt;
    running = 1'b0;
    down    = 1'b0;
    legal   = 1'b1;
    nxt     = PAUSED_UP;
    case (s)
      PAUSED_UP:   begin running = 1'b0; down = 1'b0; end
      RUN_UP:      begin running = 1'b1; down = 1'b0; end
      PAUSED_DOWN: begin running = 1'b0; down = 1'b1; end
      RUN_DOWN:    begin running = 1'b1; down = 1'b1; end
      default:     legal = 1'b0;
    endcase
    if (legal) begin
      nxt = sw_state_e'({down ^ dir_tgl, running ^ run_tgl});
    end
    return nxt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw key: 2-flop synchroniser, counting debouncer and registered rising-edge pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter tracks how many samples in a row disagree with the accepted level.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q;
    cnt_d   = '0;
    press_d = level_q & ~level_prev_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every flop samples pre-edge values, e.g. the sync chain.
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= key_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced keys drive a run/pause x up/down FSM, a prescaled
// wrapping counter, and a lap register that can freeze the display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 10,
  parameter int unsigned COUNT_MAX       = 59,
  parameter int unsigned WIDTH           = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key,
  output logic             countup,
  output logic             paused,
  output logic             lap_hold,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] display,
  output logic             wrap,
  output logic [1:0]       state_code
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'(COUNT_MAX);

  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_level_unused;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .rst    (rst),
      .key_raw(key[gi]),
      .level  (key_level_unused[gi]),
      .press  (key_press[gi])
    );
  end

  logic run_p;
  logic dir_p;
  logic lap_p;
  logic clr_p;

  assign run_p = key_press[KEY_RUN];
  assign dir_p = key_press[KEY_DIR];
  assign lap_p = key_press[KEY_LAP];
  assign clr_p = key_press[KEY_CLR];

  sw_state_e state_q;
  sw_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAUSED_UP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = toggle_state(state_q, run_p, dir_p);
  end

  assign countup    = is_up(state_q);
  assign paused     = ~is_running(state_q);
  assign state_code = state_q;

  logic [PRE_W-1:0] presc_q;
  logic [PRE_W-1:0] presc_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] lap_q;
  logic [WIDTH-1:0] lap_d;
  logic             lap_hold_q;
  logic             lap_hold_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             running;
  logic             tick;

  assign running = is_running(state_q);
  assign tick    = running && (presc_q == PRE_LAST);

  // Clear is applied last so it overrides a same-cycle tick, wrap and lap capture.
  always_comb begin
    presc_d    = presc_q;
    count_d    = count_q;
    lap_d      = lap_q;
    lap_hold_d = lap_hold_q;
    wrap_d     = 1'b0;

    if (running) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      if (countup) begin
        if (count_q == CNT_LAST) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = CNT_LAST;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end

    if (lap_p) begin
      lap_hold_d = ~lap_hold_q;
      if (!lap_hold_q) begin
        lap_d = count_q;
      end
    end

    if (clr_p) begin
      presc_d    = '0;
      count_d    = '0;
      lap_d      = '0;
      lap_hold_d = 1'b0;
      wrap_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      count_q    <= '0;
      lap_q      <= '0;
      lap_hold_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      lap_q      <= lap_d;
      lap_hold_q <= lap_hold_d;
      wrap_q     <= wrap_d;
    end
  end

  assign count    = count_q;
  assign lap_hold = lap_hold_q;
  assign wrap     = wrap_q;
  assign display  = lap_hold_q ? lap_q : count_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl with default parameters.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       countup;
  logic       paused;
  logic       lap_hold;
  logic [5:0] count;
  logic [5:0] display;
  logic       wrap;
  logic [1:0] state_code;

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .countup   (countup),
    .paused    (paused),
    .lap_hold  (lap_hold),
    .count     (count),
    .display   (display),
    .wrap      (wrap),
    .state_code(state_code)
  );

  typedef enum {SIG_STATE, SIG_COUNT, SIG_DISPLAY, SIG_COUNTUP, SIG_PAUSED, SIG_LAP, SIG_WRAP} sig_e;

  typedef struct {
    int    due;
    sig_e  sig;
    int    exp;
    string tag;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        cyc = 0;
  int        n_checks = 0;
  int        n_fail = 0;
  int        wrap_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic int read_sig(input sig_e s);
    int r;
    r = 0;
    case (s)
      SIG_STATE:   r = int'(state_code);
      SIG_COUNT:   r = int'(count);
      SIG_DISPLAY: r = int'(display);
      SIG_COUNTUP: r = int'(countup);
      SIG_PAUSED:  r = int'(paused);
      SIG_LAP:     r = int'(lap_hold);
      SIG_WRAP:    r = int'(wrap);
      default:     r = -1;
    endcase
    return r;
  endfunction

  // Queue an expectation dly cycles ahead; the queue stays sorted by due cycle.
  task automatic expect_at(input int dly, input sig_e s, input int v, input string tag);
    sb_entry_t e;
    int        pos;
    e.due = cyc + dly;
    e.sig = s;
    e.exp = v;
    e.tag = tag;
    pos   = sb.size();
    while (pos > 0 && sb[pos-1].due > e.due) pos--;
    sb.insert(pos, e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_reset_values(input int dly, input string pfx);
    expect_at(dly, SIG_STATE,   0, {pfx, "_state"});
    expect_at(dly, SIG_COUNTUP, 1, {pfx, "_countup"});
    expect_at(dly, SIG_PAUSED,  1, {pfx, "_paused"});
    expect_at(dly, SIG_COUNT,   0, {pfx, "_count"});
    expect_at(dly, SIG_DISPLAY, 0, {pfx, "_display"});
    expect_at(dly, SIG_LAP,     0, {pfx, "_lap_hold"});
    expect_at(dly, SIG_WRAP,    0, {pfx, "_wrap"});
  endtask

  // Scoreboard: compare every entry that falls due, at the falling edge.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (wrap) wrap_seen++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: slot at cycle %0d missed (now %0d)", e.tag, e.due, cyc);
        end else begin
          check(e.tag, read_sig(e.sig), e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    key = '0;
    wait_cyc(3);
    rst = 1'b0;
    expect_reset_values(50, "idle");
    wait_cyc(50);

    // Two-cycle glitch must not pass the debouncer.
    key[KEY_RUN] = 1'b1;
    wait_cyc(2);
    key[KEY_RUN] = 1'b0;
    expect_at(12, SIG_STATE, 0, "glitch_state");
    wait_cyc(12);

    // Run press: state changes 8 falling edges after the key rises.
    key[KEY_RUN] = 1'b1;
    expect_at(7,  SIG_STATE,  0, "run_latency");
    expect_at(8,  SIG_STATE,  1, "run_enter");
    expect_at(8,  SIG_PAUSED, 0, "run_paused");
    expect_at(17, SIG_COUNT,  0, "first_tick_pre");
    expect_at(18, SIG_COUNT,  1, "first_tick");
    wait_cyc(8);
    key[KEY_RUN] = 1'b0;
    wait_cyc(10);

    // Count runs up to COUNT_MAX and wraps.
    expect_at(570, SIG_COUNT,   58, "count_58");
    expect_at(579, SIG_COUNT,   58, "hold_58");
    expect_at(580, SIG_COUNT,   59, "count_59");
    expect_at(580, SIG_WRAP,    0,  "no_wrap_59");
    expect_at(580, SIG_DISPLAY, 59, "display_live");
    expect_at(590, SIG_COUNT,   0,  "up_wrap_count");
    expect_at(590, SIG_WRAP,    1,  "up_wrap");
    expect_at(591, SIG_WRAP,    0,  "wrap_one_cycle");
    wait_cyc(591);

    // Dir press at count 0: next tick counts down through the wrap.
    key[KEY_DIR] = 1'b1;
    expect_at(8, SIG_STATE,   3,  "dir_down_state");
    expect_at(8, SIG_COUNTUP, 0,  "dir_down_countup");
    expect_at(8, SIG_COUNT,   0,  "dir_down_pre");
    expect_at(9, SIG_COUNT,   59, "down_wrap_count");
    expect_at(9, SIG_WRAP,    1,  "down_wrap");
    wait_cyc(8);
    key[KEY_DIR] = 1'b0;
    wait_cyc(9);

    // Pause with the prescaler at 6, then resume: tick 3 cycles later.
    key[KEY_RUN] = 1'b1;
    expect_at(8,  SIG_STATE, 2,  "pause_state");
    expect_at(8,  SIG_COUNT, 58, "pause_count");
    expect_at(38, SIG_COUNT, 58, "paused_hold");
    wait_cyc(8);
    key[KEY_RUN] = 1'b0;
    wait_cyc(30);
    key[KEY_RUN] = 1'b1;
    expect_at(8,  SIG_STATE, 3,  "resume_state");
    expect_at(11, SIG_COUNT, 58, "resume_pre_tick");
    expect_at(12, SIG_COUNT, 57, "resume_tick");
    wait_cyc(8);
    key[KEY_RUN] = 1'b0;
    wait_cyc(4);

    // Clear keeps the state and restarts the prescaler.
    key[KEY_CLR] = 1'b1;
    expect_at(7, SIG_COUNT, 57, "clr_latency");
    expect_at(8, SIG_COUNT, 0,  "clr_count");
    expect_at(8, SIG_STATE, 3,  "clr_state_kept");
    expect_at(8, SIG_LAP,   0,  "clr_lap_hold");
    wait_cyc(8);
    key[KEY_CLR] = 1'b0;
    key[KEY_DIR] = 1'b1;
    expect_at(8,  SIG_STATE, 1, "dir_up_state");
    expect_at(9,  SIG_COUNT, 0, "clr_presc_pre");
    expect_at(10, SIG_COUNT, 1, "clr_presc_tick");
    wait_cyc(8);
    key[KEY_DIR] = 1'b0;
    wait_cyc(107);

    // Lap at count 12 freezes the display while the count runs on.
    key[KEY_LAP] = 1'b1;
    expect_at(8, SIG_LAP,     1,  "lap_on");
    expect_at(8, SIG_DISPLAY, 12, "lap_display");
    expect_at(8, SIG_COUNT,   12, "lap_count");
    wait_cyc(8);
    key[KEY_LAP] = 1'b0;
    expect_at(77, SIG_COUNT,   20, "lap_count_runs");
    expect_at(77, SIG_DISPLAY, 12, "lap_frozen");
    wait_cyc(71);
    key[KEY_LAP] = 1'b1;
    expect_at(8, SIG_LAP,     0,  "lap_off");
    expect_at(8, SIG_DISPLAY, 20, "lap_off_display");
    expect_at(8, SIG_COUNT,   20, "lap_off_count");
    wait_cyc(8);
    key[KEY_LAP] = 1'b0;
    wait_cyc(10);

    // Clear together with lap (and a same-cycle tick): clear wins.
    key[KEY_LAP] = 1'b1;
    key[KEY_CLR] = 1'b1;
    expect_at(8, SIG_COUNT,   0, "clr_lap_count");
    expect_at(8, SIG_LAP,     0, "clr_lap_hold_off");
    expect_at(8, SIG_DISPLAY, 0, "clr_lap_display");
    expect_at(8, SIG_STATE,   1, "clr_lap_state");
    expect_at(8, SIG_WRAP,    0, "clr_lap_wrap");
    wait_cyc(8);
    key = '0;
    wait_cyc(10);

    // Pause, then run and dir in the same cycle: PAUSED_UP -> RUN_DOWN.
    key[KEY_RUN] = 1'b1;
    expect_at(8, SIG_STATE, 0, "pause_up");
    expect_at(8, SIG_COUNT, 1, "pause_up_count");
    wait_cyc(8);
    key[KEY_RUN] = 1'b0;
    wait_cyc(10);
    key[KEY_RUN] = 1'b1;
    key[KEY_DIR] = 1'b1;
    expect_at(8,  SIG_STATE,  3,  "run_dir_same_cycle");
    expect_at(8,  SIG_PAUSED, 0,  "run_dir_paused");
    expect_at(9,  SIG_COUNT,  1,  "run_dir_pre_tick");
    expect_at(10, SIG_COUNT,  0,  "run_dir_tick");
    expect_at(10, SIG_WRAP,   0,  "run_dir_no_wrap");
    expect_at(20, SIG_COUNT,  59, "run_dir_wrap_count");
    expect_at(20, SIG_WRAP,   1,  "run_dir_wrap");
    wait_cyc(8);
    key = '0;
    wait_cyc(8);

    // Reset mid-run with a key press still in the debouncer.
    key[KEY_RUN] = 1'b1;
    wait_cyc(4);
    rst = 1'b1;
    key = '0;
    expect_reset_values(1, "midrst");
    expect_at(20, SIG_STATE,  0, "midrst_no_press");
    expect_at(20, SIG_COUNT,  0, "midrst_count_hold");
    expect_at(20, SIG_PAUSED, 1, "midrst_paused_hold");
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(21);

    check("wrap_pulses", wrap_seen, 3);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
